ham_secded_dec_pipe: RTL and testbench

Pipelined, multi-channel SECDED Hamming decoder with a valid/ready handshake. It is the clocked successor to the two-port combinational decoder.
- NUM_CH channels advance in lockstep through a 2-stage pipeline.
- Each channel is corrected and classified independently.
- Per-channel saturating error counters are optional.
- Sits between the banked memory read path and downstream consumers.

---
 rtl/ham_pkg.sv | 36 +++
 rtl/ham_syndrome_calc.sv | 22 ++
 rtl/ham_secded_dec_pipe.sv | 149 ++++++++++++++
 tb/tb_ham_secded_dec_pipe.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared types and elaboration-time helpers for the SECDED Hamming decoder.
// Codeword positions are 1-based; power-of-two positions carry Hamming parity.
package ham_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_SINGLE,
        ERR_PARITY,
        ERR_DOUBLE
    } err_class_e;

    // Smallest p such that 2**p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 0;
        for (int q = 1; q < 31; q++) begin
            if (p == 0 && (1 << q) >= data_w + q + 1) p = q;
        end
        return p;
    endfunction

    function automatic bit is_pow2(input int k);
        return (k > 0) && ((k & (k - 1)) == 0);
    endfunction

    // Data bit index carried by a non-power-of-two position k.
    function automatic int pos_to_data_idx(input int k);
        int n;
        n = 0;
        for (int j = 0; j < 31; j++) begin
            if ((1 << j) <= k) n++;
        end
        return k - n - 1;
    endfunction

endpackage

// File: rtl/ham_syndrome_calc.sv
// Combinational syndrome and overall parity of one SECDED codeword.
// Bit k-1 of cw holds position k; bit CW_W-1 is the overall parity position.
module ham_syndrome_calc #(
    parameter int CW_W  = 8,
    parameter int PAR_W = 3
) (
    input  logic [CW_W-1:0]  cw,
    output logic [PAR_W-1:0] syn,
    output logic             par
);

    always_comb begin
        syn = '0;
        for (int k = 1; k < CW_W; k++) begin
            for (int j = 0; j < PAR_W; j++) begin
                if (((k >> j) & 1) == 1) syn[j] = syn[j] ^ cw[k-1];
            end
        end
        par = ^cw;
    end

endmodule

// File: rtl/ham_secded_dec_pipe.sv
// Two-stage, multi-channel SECDED decoder with a shared valid/ready handshake.
// Per-channel saturating error counters exist only when HAM_DEC_ERR_CNT_EN is defined.
module ham_secded_dec_pipe
    import ham_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    localparam int PAR_W   = calc_par_w(DATA_W),
    localparam int CW_W    = DATA_W + PAR_W + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_CH*CW_W-1:0]   i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic [NUM_CH-1:0]        o_sbit_err,
    output logic [NUM_CH-1:0]        o_dbit_err,
    input  logic                     i_cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]  o_sbit_cnt,
    output logic [NUM_CH*CNT_W-1:0]  o_dbit_cnt
);

    // Handshake: a transfer happens on a clock edge where valid && ready are both
    // high; valid never waits on ready, and payloads hold while valid && !ready.
    logic                             s1_valid;
    logic [NUM_CH-1:0][PAR_W-1:0]     s1_syn;
    logic [NUM_CH-1:0]                s1_par;
    logic [NUM_CH-1:0][DATA_W-1:0]    s1_raw;

    logic [NUM_CH-1:0][PAR_W-1:0]     in_syn;
    logic [NUM_CH-1:0]                in_par;
    logic [NUM_CH-1:0][DATA_W-1:0]    in_raw;

    logic [NUM_CH-1:0][DATA_W-1:0]    fix_data;
    logic [NUM_CH-1:0]                s2_sbit;
    logic [NUM_CH-1:0]                s2_dbit;

    logic out_adv;
    logic s1_load;

    assign out_adv = !o_valid || i_ready;
    assign o_ready = !s1_valid || out_adv;
    assign s1_load = i_valid && o_ready;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] flip_mask;
        err_class_e        cls;
        logic              in_range;

        ham_syndrome_calc #(
            .CW_W  (CW_W),
            .PAR_W (PAR_W)
        ) u_syn (
            .cw  (i_data[c*CW_W +: CW_W]),
            .syn (in_syn[c]),
            .par (in_par[c])
        );

        // Stage 1 keeps only the data bits; the syndrome says which one to flip.
        for (genvar k = 1; k < CW_W; k++) begin : g_pos
            if (!is_pow2(k)) begin : g_data
                assign in_raw[c][pos_to_data_idx(k)] = i_data[c*CW_W + k - 1];
                assign flip_mask[pos_to_data_idx(k)] = (s1_syn[c] == PAR_W'(k));
            end
        end

        assign in_range = int'(s1_syn[c]) <= CW_W - 1;

        always_comb begin
            cls = ERR_NONE;
            if (s1_syn[c] == '0) begin
                if (s1_par[c]) cls = ERR_PARITY;
            end else if (!s1_par[c]) begin
                cls = ERR_DOUBLE;
            end else if (in_range) begin
                cls = ERR_SINGLE;
            end else begin
                cls = ERR_DOUBLE;
            end
        end

        // A single error on a parity position leaves flip_mask empty.
        assign fix_data[c] = (cls == ERR_SINGLE) ? (s1_raw[c] ^ flip_mask) : s1_raw[c];
        assign s2_sbit[c]  = (cls == ERR_SINGLE) || (cls == ERR_PARITY);
        assign s2_dbit[c]  = (cls == ERR_DOUBLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_syn     <= '0;
            s1_par     <= '0;
            s1_raw     <= '0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_sbit_err <= '0;
            o_dbit_err <= '0;
        end else begin
            if (o_ready) s1_valid <= i_valid;
            if (s1_load) begin
                s1_syn <= in_syn;
                s1_par <= in_par;
                s1_raw <= in_raw;
            end
            if (out_adv) o_valid <= s1_valid;
            if (s1_valid && out_adv) begin
                o_data     <= fix_data;
                o_sbit_err <= s2_sbit;
                o_dbit_err <= s2_dbit;
            end
        end
    end

`ifdef HAM_DEC_ERR_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] sbit_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] dbit_cnt;
    logic                         out_fire;

    assign out_fire = o_valid && i_ready;

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            sbit_cnt <= '0;
            dbit_cnt <= '0;
        end else if (out_fire) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (o_sbit_err[c] && (sbit_cnt[c] != {CNT_W{1'b1}}))
                    sbit_cnt[c] <= sbit_cnt[c] + CNT_W'(1);
                if (o_dbit_err[c] && (dbit_cnt[c] != {CNT_W{1'b1}}))
                    dbit_cnt[c] <= dbit_cnt[c] + CNT_W'(1);
            end
        end
    end

    assign o_sbit_cnt = sbit_cnt;
    assign o_dbit_cnt = dbit_cnt;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = i_cnt_clr;
    assign o_sbit_cnt     = '0;
    assign o_dbit_cnt     = '0;
`endif

endmodule

// File: tb/tb_ham_secded_dec_pipe.sv
// Self-checking bench for ham_secded_dec_pipe: directed vectors, backpressure,
// random streams and counter behaviour (counter expectations follow HAM_DEC_ERR_CNT_EN).
module tb_ham_secded_dec_pipe;

    localparam int DATA_W = 4;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;
    localparam int PAR_W  = 3;
    localparam int CW_W   = DATA_W + PAR_W + 1;
    localparam int EW     = DATA_W + 2;
    localparam int EXP_W  = NUM_CH * EW;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAM_DEC_ERR_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic                     i_clk;
    logic                     i_rst;
    logic                     i_valid;
    logic                     o_ready;
    logic [NUM_CH*CW_W-1:0]   i_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [NUM_CH*DATA_W-1:0] o_data;
    logic [NUM_CH-1:0]        o_sbit_err;
    logic [NUM_CH-1:0]        o_dbit_err;
    logic                     i_cnt_clr;
    logic [NUM_CH*CNT_W-1:0]  o_sbit_cnt;
    logic [NUM_CH*CNT_W-1:0]  o_dbit_cnt;

    // Second instance at DATA_W=8 reaches syndromes beyond the last position.
    logic        d8_valid;
    logic        d8_ready_o;
    logic [12:0] d8_data;
    logic        d8_ovalid;
    logic [7:0]  d8_odata;
    logic        d8_sbit;
    logic        d8_dbit;
    logic [7:0]  d8_scnt;
    logic [7:0]  d8_dcnt;

    int checks;
    int errors;
    int n_pop;
    int cyc;
    int cnt_s[NUM_CH];
    int cnt_d[NUM_CH];
    logic [EXP_W-1:0] exp_q[$];

    ham_secded_dec_pipe #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_sbit_err (o_sbit_err),
        .o_dbit_err (o_dbit_err),
        .i_cnt_clr  (i_cnt_clr),
        .o_sbit_cnt (o_sbit_cnt),
        .o_dbit_cnt (o_dbit_cnt)
    );

    ham_secded_dec_pipe #(.DATA_W(8), .NUM_CH(1), .CNT_W(8)) dut8 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (d8_valid),
        .o_ready    (d8_ready_o),
        .i_data     (d8_data),
        .o_valid    (d8_ovalid),
        .i_ready    (1'b1),
        .o_data     (d8_odata),
        .o_sbit_err (d8_sbit),
        .o_dbit_err (d8_dbit),
        .i_cnt_clr  (1'b0),
        .o_sbit_cnt (d8_scnt),
        .o_dbit_cnt (d8_dcnt)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        int di;
        int s;
        cw = '0;
        di = 0;
        for (int k = 1; k < CW_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                cw[k-1] = d[di];
                di++;
            end
        end
        s = 0;
        for (int k = 1; k < CW_W; k++) if (cw[k-1]) s ^= k;
        for (int j = 0; j < PAR_W; j++) if (((s >> j) & 1) == 1) cw[(1 << j) - 1] = 1'b1;
        cw[CW_W-1] = ^cw[CW_W-2:0];
        return cw;
    endfunction

    // Returns {dbit, sbit, data}.
    function automatic logic [EW-1:0] ref_decode(input logic [CW_W-1:0] cw);
        int s;
        int di;
        logic p, sb, db;
        logic [CW_W-1:0] f;
        logic [DATA_W-1:0] d;
        s = 0;
        for (int k = 1; k < CW_W; k++) if (cw[k-1]) s ^= k;
        p = ^cw;
        f = cw;
        sb = 1'b0;
        db = 1'b0;
        if (s == 0) sb = p;
        else if (!p) db = 1'b1;
        else if (s <= CW_W - 1) begin
            f[s-1] = ~f[s-1];
            sb = 1'b1;
        end else db = 1'b1;
        di = 0;
        d = '0;
        for (int k = 1; k < CW_W; k++) begin
            if ((k & (k - 1)) != 0) begin
                d[di] = f[k-1];
                di++;
            end
        end
        return {db, sb, d};
    endfunction

    function automatic logic [CW_W-1:0] rand_cw(input int kind);
        logic [CW_W-1:0] cw;
        int a, b;
        cw = encode(DATA_W'($urandom));
        a = $urandom_range(0, CW_W - 1);
        if (kind >= 1) cw[a] = ~cw[a];
        if (kind == 2) begin
            b = (a + $urandom_range(1, CW_W - 1)) % CW_W;
            cw[b] = ~cw[b];
        end
        return cw;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge i_clk) begin : scoreboard
        logic [EXP_W-1:0] ex;
        logic [EW-1:0]    r;
        logic [NUM_CH*DATA_W-1:0] ed;
        logic [NUM_CH-1:0] es, edb;
        logic exp_ready;
        if (i_rst) begin
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_s[c] = 0;
                cnt_d[c] = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (o_sbit_cnt[c*CNT_W +: CNT_W] !== CNT_W'(cnt_s[c]) ||
                    o_dbit_cnt[c*CNT_W +: CNT_W] !== CNT_W'(cnt_d[c])) begin
                    errors++;
                    $display("FAIL counters ch%0d: got s=%0d d=%0d expected s=%0d d=%0d", c,
                             o_sbit_cnt[c*CNT_W +: CNT_W], o_dbit_cnt[c*CNT_W +: CNT_W], cnt_s[c], cnt_d[c]);
                end
            end
            exp_ready = (exp_q.size() < 2) || i_ready;
            checks++;
            if (o_ready !== exp_ready) begin
                errors++;
                $display("FAIL o_ready: got %b expected %b (in flight %0d)", o_ready, exp_ready, exp_q.size());
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_out: o_valid=1 with nothing in flight, expected 0");
                end else begin
                    ex = exp_q[0];
                    if ({o_dbit_err, o_sbit_err, o_data} !== ex) begin
                        errors++;
                        $display("FAIL out_word: got dbit=%b sbit=%b data=%h expected dbit=%b sbit=%b data=%h",
                                 o_dbit_err, o_sbit_err, o_data,
                                 ex[EXP_W-1 -: NUM_CH], ex[NUM_CH*DATA_W +: NUM_CH], ex[NUM_CH*DATA_W-1:0]);
                    end
                    if (i_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                        if (CNT_ON == 1) begin
                            for (int c = 0; c < NUM_CH; c++) begin
                                if (ex[NUM_CH*DATA_W + c] && cnt_s[c] < CNT_MAX) cnt_s[c]++;
                                if (ex[NUM_CH*DATA_W + NUM_CH + c] && cnt_d[c] < CNT_MAX) cnt_d[c]++;
                            end
                        end
                    end
                end
            end
            if (i_cnt_clr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    cnt_s[c] = 0;
                    cnt_d[c] = 0;
                end
            end
            if (i_valid && o_ready) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r = ref_decode(i_data[c*CW_W +: CW_W]);
                    ed[c*DATA_W +: DATA_W] = r[DATA_W-1:0];
                    es[c]  = r[DATA_W];
                    edb[c] = r[DATA_W+1];
                end
                exp_q.push_back({edb, es, ed});
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [NUM_CH*CW_W-1:0] w);
        bit ok;
        ok = 1'b0;
        i_data  = w;
        i_valid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge i_clk);
            if (o_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: o_ready=%b after 500 cycles, expected 1", o_ready);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge i_clk);
            t++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words still in flight, expected 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0; i_data = '0;
        d8_valid = 1'b0; d8_data = '0;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== '0 || o_sbit_err !== '0 ||
            o_dbit_err !== '0 || o_sbit_cnt !== '0 || o_dbit_cnt !== '0 || d8_ovalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b data=%h sb=%b db=%b expected 0 1 0 0 0",
                     o_valid, o_ready, o_data, o_sbit_err, o_dbit_err);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_vectors();
        // Clean words: also confirms the two-cycle latency.
        send({8'h55, 8'h55});
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: o_valid=%b one cycle after accept, expected 0", o_valid);
        end
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hBB || o_sbit_err !== 2'b00 || o_dbit_err !== 2'b00) begin
            errors++;
            $display("FAIL clean: got v=%b data=%h sb=%b db=%b expected 1 bb 00 00", o_valid, o_data, o_sbit_err, o_dbit_err);
        end
        @(posedge i_clk); #1;
        // Data-position error on ch0, overall-parity error on ch1.
        send({8'hD5, 8'h45});
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hBB || o_sbit_err !== 2'b11 || o_dbit_err !== 2'b00) begin
            errors++;
            $display("FAIL single: got v=%b data=%h sb=%b db=%b expected 1 bb 11 00", o_valid, o_data, o_sbit_err, o_dbit_err);
        end
        @(negedge i_clk);
        checks++;
        if (o_sbit_cnt !== {CNT_W'(CNT_ON), CNT_W'(CNT_ON)}) begin
            errors++;
            $display("FAIL sbit_cnt_inc: got %h expected both channels %0d", o_sbit_cnt, CNT_ON);
        end
        @(posedge i_clk); #1;
        // Two data positions flipped on ch0.
        send({8'h55, 8'h41});
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== 8'hB8 || o_sbit_err !== 2'b00 || o_dbit_err !== 2'b01) begin
            errors++;
            $display("FAIL double: got v=%b data=%h sb=%b db=%b expected 1 b8 00 01", o_valid, o_data, o_sbit_err, o_dbit_err);
        end
        @(negedge i_clk);
        checks++;
        if (o_dbit_cnt[CNT_W-1:0] !== CNT_W'(CNT_ON)) begin
            errors++;
            $display("FAIL dbit_cnt_inc: got %0d expected %0d", o_dbit_cnt[CNT_W-1:0], CNT_ON);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_invalid_pos();
        logic [12:0] words[4];
        logic [9:0]  exps[4];  // {dbit, sbit, data}
        words[0] = 13'h0089; exps[0] = {1'b1, 1'b0, 8'h00};  // positions 1,4,8: s=13
        words[1] = 13'h0414; exps[1] = {1'b1, 1'b0, 8'h43};  // positions 3,5,11: s=13
        words[2] = 13'h0800; exps[2] = {1'b0, 1'b1, 8'h00};  // position 12 only
        words[3] = 13'h1000; exps[3] = {1'b0, 1'b1, 8'h00};  // overall parity only
        for (int i = 0; i < 4; i++) begin
            d8_data  = words[i];
            d8_valid = 1'b1;
            @(posedge i_clk); #1;
            d8_valid = 1'b0;
            @(posedge i_clk);
            @(negedge i_clk);
            checks++;
            if (d8_ovalid !== 1'b1 || {d8_dbit, d8_sbit, d8_odata} !== exps[i]) begin
                errors++;
                $display("FAIL dw8_word%0d: got v=%b db=%b sb=%b data=%h expected 1 %b %b %h", i,
                         d8_ovalid, d8_dbit, d8_sbit, d8_odata, exps[i][9], exps[i][8], exps[i][7:0]);
            end
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int c0, c1;
        i_ready = 1'b1;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 40; i++) begin
            send({rand_cw($urandom_range(0, 2)), rand_cw($urandom_range(0, 2))});
            if (i == 0) c0 = cyc;
            c1 = cyc;
        end
        checks++;
        if (c1 - c0 != 39) begin
            errors++;
            $display("FAIL throughput: 40 words took %0d cycles between first and last accept, expected 39", c1 - c0);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int p0;
        bit saw_stall;
        p0 = n_pop;
        saw_stall = 1'b0;
        i_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send({rand_cw(1), rand_cw($urandom_range(0, 2))});
            end
            begin
                @(posedge i_clk); @(posedge i_clk); #1;
                i_ready = 1'b0;
                repeat (3) begin
                    @(negedge i_clk);
                    if (o_ready == 1'b0) saw_stall = 1'b1;
                    @(posedge i_clk); #1;
                end
                i_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (!saw_stall || n_pop - p0 != 6) begin
            errors++;
            $display("FAIL backpressure: stall_seen=%b words_out=%0d expected 1 and 6", saw_stall, n_pop - p0);
        end
    endtask

    task automatic test_random_stream();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge i_clk); #1;
                    end
                    send({rand_cw($urandom_range(0, 2)), rand_cw($urandom_range(0, 2))});
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    i_ready = ($urandom_range(0, 2) != 0);
                    i_cnt_clr = ($urandom_range(0, 40) == 0);
                    @(posedge i_clk); #1;
                end
                i_cnt_clr = 1'b0;
                i_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_saturation();
        logic [CW_W-1:0] good;
        logic [CW_W-1:0] bad;
        i_ready = 1'b1;
        good = encode(4'h6);
        for (int i = 0; i < 300; i++) begin
            bad = good;
            bad[i % CW_W] = ~bad[i % CW_W];
            send({bad, good});
        end
        drain();
        @(negedge i_clk);
        checks++;
        if (o_sbit_cnt[CNT_W +: CNT_W] !== CNT_W'(CNT_ON * CNT_MAX)) begin
            errors++;
            $display("FAIL saturate: ch1 sbit_cnt=%0d expected %0d", o_sbit_cnt[CNT_W +: CNT_W], CNT_ON * CNT_MAX);
        end
        @(posedge i_clk); #1;
        // Clear in the same cycle as an error word's output handshake.
        bad = good;
        bad[2] = ~bad[2];
        send({bad, good});
        @(posedge i_clk); #1;
        i_cnt_clr = 1'b1;
        @(posedge i_clk); #1;
        i_cnt_clr = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_sbit_cnt !== '0 || o_dbit_cnt !== '0) begin
            errors++;
            $display("FAIL clear_wins: sbit_cnt=%h dbit_cnt=%h expected 0 0", o_sbit_cnt, o_dbit_cnt);
        end
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset_midstream();
        i_ready = 1'b0;
        send({rand_cw(1), rand_cw(2)});
        send({rand_cw(0), rand_cw(1)});
        i_data  = {rand_cw(0), rand_cw(0)};
        i_valid = 1'b1;
        i_rst   = 1'b1;
        @(posedge i_clk); #1;
        i_rst   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_sbit_cnt !== '0 || o_dbit_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid: got valid=%b ready=%b scnt=%h dcnt=%h expected 0 1 0 0",
                     o_valid, o_ready, o_sbit_cnt, o_dbit_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_drop: stale output at cycle %0d after reset, o_valid=%b expected 0", i + 1, o_valid);
            end
        end
        @(posedge i_clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_pop  = 0;
        cyc    = 0;
        test_reset();
        test_vectors();
        test_invalid_pos();
        test_back_to_back();
        test_backpressure();
        test_random_stream();
        test_saturation();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
